dispatcher: RTL and testbench
=============================

DISPATCHER -- requirements
Module: dispatcher

Interface
REQ-001 SHALL take parameters: ADDR_WIDTH 32 (PC width); ROB_WIDTH 4 (ROB index width); EX_ROB_WIDTH 5 (tag width with no-dependency code); NON_DEP 16 (tag meaning operand ready).
REQ-002 SHALL have ports: clk_in in 1, system clock; rst_in in 1, synchronous active-low reset; rdy_in in 1, pause when low.
REQ-003 SHALL have fetch ports: IF2DP_en in 1, instruction valid; IF2DP_inst in 32, instruction; IF2DP_pc in ADDR_WIDTH, instruction PC; DP2IF_stall out 1, do not present new instruction.
REQ-004 SHALL have register-file ports: DP2RF_rs1 out 5 and DP2RF_rs2 out 5, combinational source query; RF2DP_Qj/Qk in EX_ROB_WIDTH, source tags; RF2DP_Vj/Vk in 32, source values; DP2RF_rename_en out 1; DP2RF_rd out 5; DP2RF_ROB_index out ROB_WIDTH.
REQ-005 SHALL have ROB ports: ROB2DP_full in 1; ROB2DP_tail in ROB_WIDTH, next free index; ROB2DP_clear in 1, mispredict flush; DP2ROB_en out 1; DP2ROB_opcode out 7; DP2ROB_rd out 5; DP2ROB_pc out ADDR_WIDTH.
REQ-006 SHALL have RS ports: DP2RS_en out 1; DP2RS_pc out ADDR_WIDTH; DP2RS_Qj/Qk out EX_ROB_WIDTH; DP2RS_Vj/Vk out 32; DP2RS_imm out 32; DP2RS_opcode out 7; DP2RS_ROB_index out ROB_WIDTH; RS2DP_full in 1.
REQ-007 SHALL have LSB ports DP2LSB_* with the same names, widths and meaning as the DP2RS_* ports, plus LSB2DP_full in 1.
REQ-008 SHALL have CDB snoop ports: RS2CDB_en in 1; RS2CDB_ROB_index in ROB_WIDTH; RS2CDB_value in 32; CDB2RS_LSB_en in 1; CDB2RS_LSB_ROB_index in ROB_WIDTH; CDB2RS_LSB_value in 32.

Function
REQ-009 SHALL hold one instruction register, with states IDLE (empty) and HOLD (occupied).
REQ-010 SHALL accept an instruction on a clock edge with rdy_in=1, IF2DP_en=1 and DP2IF_stall=0. IDLE goes to HOLD.
REQ-011 SHALL route by opcode: 0000011 (load) and 0100011 (store) go to LSB; 0110011, 0010011, 0110111, 0010111, 1101111, 1100111 and 1100011 go to RS.
REQ-012 SHALL treat any other opcode as a NOP: it is dropped on the next edge with no issue and no ROB entry.
REQ-013 SHALL define can_issue = HOLD and !ROB2DP_full and !(target unit full).
REQ-014 SHALL set DP2IF_stall = HOLD and !can_issue, combinationally.
REQ-015 SHALL, on an edge with can_issue and rdy_in=1, register exactly one DP2RS_en or DP2LSB_en pulse together with DP2ROB_en.
REQ-016 SHALL register DP2RF_rename_en in that same issue only when rd≠0 and the opcode is neither store nor branch.
REQ-017 SHALL set the issued ROB_index to ROB2DP_tail.
REQ-018 SHALL, when accept and issue occur on the same edge, stay in HOLD, sustaining 1 instruction per cycle.
REQ-019 SHALL set issue latency to one edge after acceptance when resources are free; DP2*_en is visible in the following cycle.
REQ-020 SHALL build immediates per RV32I I/S/B/U/J formats, sign-extended to 32 bits; R-type immediate is 0.
REQ-021 SHALL give an unused source (LUI, AUIPC, JAL; rs2 of I-type and loads) or a source equal to x0 the tag NON_DEP and value 0.
REQ-022 SHALL resolve operand forwarding at issue in this priority: RS2CDB match, then CDB2RS_LSB match, then RF value. A CDB match sets tag=NON_DEP and value=CDB value.
REQ-023 SHALL, on ROB2DP_clear=1, discard the held instruction, force every DP2*_en low on the next edge and go to IDLE; a simultaneous IF2DP_en is ignored.
REQ-024 SHALL, when rdy_in=0, hold all state and drive all DP2*_en low.

Reset
REQ-025 SHALL, with rst_in=0 at a clock edge, go to IDLE and clear all DP2*_en, DP2RF_rename_en and all data outputs to 0.
REQ-026 SHALL have reset override clear and rdy_in, and abort any held instruction with no issue.

Structure
REQ-027 SHALL place opcode constants, ADDR_WIDTH, ROB_WIDTH, EX_ROB_WIDTH and NON_DEP in a shared cpu_defs package.
REQ-028 SHALL contain one sub-module, imm_gen (combinational immediate and format decode).

Verification
REQ-029 SHALL test: 0x00500093 (addi x1,x0,5) at PC 0, tail 2 -> DP2RS_en, opcode 0010011, imm 5, Qj=Qk=16, Vj=0, ROB_index 2, rename rd 1.
REQ-030 SHALL test: 0x0020A423 (sw x2,8(x1)) -> DP2LSB_en, imm 8, no rename, DP2RS_en=0.
REQ-031 SHALL test: add held while RS2DP_full=1 for 3 cycles -> stall high for 3 cycles, then exactly one DP2RS_en pulse.
REQ-032 SHALL test: RF2DP_Qj=3 with RS2CDB_en=1, index 3, value 0xDEADBEEF at the issue edge -> DP2RS_Qj=16, DP2RS_Vj=0xDEADBEEF.
REQ-033 SHALL test: ROB2DP_clear during HOLD with the ROB full -> no issue pulse, IDLE, stall=0.
REQ-034 SHALL test: rst_in=0 mid-HOLD, then released -> no issue, all outputs 0.

Source files
------------

// File: rtl/dispatcher_pkg.sv
// ==========================================================================
// Package : cpu_defs
// Shared CPU widths, RV32I opcodes and the dispatch-target encoding.
// Rev     : 1.0
// ==========================================================================
`default_nettype none

package cpu_defs;
   localparam int ADDR_WIDTH   = 32;
   localparam int ROB_WIDTH    = 4;
   localparam int EX_ROB_WIDTH = 5;
   localparam int NON_DEP      = 16;

   localparam logic [6:0] c_op_load   = 7'b0000011;
   localparam logic [6:0] c_op_store  = 7'b0100011;
   localparam logic [6:0] c_op_op     = 7'b0110011;
   localparam logic [6:0] c_op_imm    = 7'b0010011;
   localparam logic [6:0] c_op_lui    = 7'b0110111;
   localparam logic [6:0] c_op_auipc  = 7'b0010111;
   localparam logic [6:0] c_op_jal    = 7'b1101111;
   localparam logic [6:0] c_op_jalr   = 7'b1100111;
   localparam logic [6:0] c_op_branch = 7'b1100011;

   typedef enum logic [1:0] {
      UNIT_NONE = 2'd0,
      UNIT_RS   = 2'd1,
      UNIT_LSB  = 2'd2
   } unit_e;
endpackage

`default_nettype wire

// File: rtl/dispatcher_imm_gen.sv
// ==========================================================================
// Module : imm_gen
// Combinational RV32I format decode: immediate, target unit, operand usage.
// Rev    : 1.0
// ==========================================================================
`default_nettype none

module imm_gen
   import cpu_defs::*;
(
   input  logic [31:0] inst,
   output logic [31:0] imm,
   output unit_e       unit,
   output logic        use_rs1,
   output logic        use_rs2,
   output logic        has_rd
);
   logic [2:0] w_unused_funct3;
   assign w_unused_funct3 = inst[14:12];

   always_comb begin
      imm     = 32'd0;
      unit    = UNIT_NONE;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      has_rd  = 1'b0;
      case (inst[6:0])
         c_op_load: begin
            imm = {{20{inst[31]}}, inst[31:20]};
            unit = UNIT_LSB; use_rs1 = 1'b1; has_rd = 1'b1;
         end
         c_op_store: begin
            imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            unit = UNIT_LSB; use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         c_op_op: begin
            unit = UNIT_RS; use_rs1 = 1'b1; use_rs2 = 1'b1; has_rd = 1'b1;
         end
         c_op_imm, c_op_jalr: begin
            imm = {{20{inst[31]}}, inst[31:20]};
            unit = UNIT_RS; use_rs1 = 1'b1; has_rd = 1'b1;
         end
         c_op_lui, c_op_auipc: begin
            imm = {inst[31:12], 12'd0};
            unit = UNIT_RS; has_rd = 1'b1;
         end
         c_op_jal: begin
            imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            unit = UNIT_RS; has_rd = 1'b1;
         end
         c_op_branch: begin
            imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            unit = UNIT_RS; use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

`default_nettype wire

// File: rtl/dispatcher.sv
// ==========================================================================
// Module : dispatcher
// One-entry decode/issue stage feeding RS, LSB, ROB and register renaming.
// Rev    : 1.0
// ==========================================================================
`default_nettype none

module dispatcher #(
   parameter int ADDR_WIDTH   = cpu_defs::ADDR_WIDTH,
   parameter int ROB_WIDTH    = cpu_defs::ROB_WIDTH,
   parameter int EX_ROB_WIDTH = cpu_defs::EX_ROB_WIDTH,
   parameter int NON_DEP      = cpu_defs::NON_DEP
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    rdy_in,
   input  logic                    IF2DP_en,
   input  logic [31:0]             IF2DP_inst,
   input  logic [ADDR_WIDTH-1:0]   IF2DP_pc,
   output logic                    DP2IF_stall,
   output logic [4:0]              DP2RF_rs1,
   output logic [4:0]              DP2RF_rs2,
   input  logic [EX_ROB_WIDTH-1:0] RF2DP_Qj,
   input  logic [EX_ROB_WIDTH-1:0] RF2DP_Qk,
   input  logic [31:0]             RF2DP_Vj,
   input  logic [31:0]             RF2DP_Vk,
   output logic                    DP2RF_rename_en,
   output logic [4:0]              DP2RF_rd,
   output logic [ROB_WIDTH-1:0]    DP2RF_ROB_index,
   input  logic                    ROB2DP_full,
   input  logic [ROB_WIDTH-1:0]    ROB2DP_tail,
   input  logic                    ROB2DP_clear,
   output logic                    DP2ROB_en,
   output logic [6:0]              DP2ROB_opcode,
   output logic [4:0]              DP2ROB_rd,
   output logic [ADDR_WIDTH-1:0]   DP2ROB_pc,
   output logic                    DP2RS_en,
   output logic [ADDR_WIDTH-1:0]   DP2RS_pc,
   output logic [EX_ROB_WIDTH-1:0] DP2RS_Qj,
   output logic [EX_ROB_WIDTH-1:0] DP2RS_Qk,
   output logic [31:0]             DP2RS_Vj,
   output logic [31:0]             DP2RS_Vk,
   output logic [31:0]             DP2RS_imm,
   output logic [6:0]              DP2RS_opcode,
   output logic [ROB_WIDTH-1:0]    DP2RS_ROB_index,
   input  logic                    RS2DP_full,
   output logic                    DP2LSB_en,
   output logic [ADDR_WIDTH-1:0]   DP2LSB_pc,
   output logic [EX_ROB_WIDTH-1:0] DP2LSB_Qj,
   output logic [EX_ROB_WIDTH-1:0] DP2LSB_Qk,
   output logic [31:0]             DP2LSB_Vj,
   output logic [31:0]             DP2LSB_Vk,
   output logic [31:0]             DP2LSB_imm,
   output logic [6:0]              DP2LSB_opcode,
   output logic [ROB_WIDTH-1:0]    DP2LSB_ROB_index,
   input  logic                    LSB2DP_full,
   input  logic                    RS2CDB_en,
   input  logic [ROB_WIDTH-1:0]    RS2CDB_ROB_index,
   input  logic [31:0]             RS2CDB_value,
   input  logic                    CDB2RS_LSB_en,
   input  logic [ROB_WIDTH-1:0]    CDB2RS_LSB_ROB_index,
   input  logic [31:0]             CDB2RS_LSB_value
);
   import cpu_defs::*;

   localparam logic [0:0] c_idle = 1'b0;
   localparam logic [0:0] c_hold = 1'b1;
   localparam logic [EX_ROB_WIDTH-1:0] c_non_dep = EX_ROB_WIDTH'(NON_DEP);

   logic [0:0]              r_state;
   logic [31:0]             r_inst;
   logic [ADDR_WIDTH-1:0]   r_pc;
   logic                    r_rs_en, r_lsb_en, r_rob_en, r_rename_en;
   logic [ADDR_WIDTH-1:0]   r_issue_pc;
   logic [EX_ROB_WIDTH-1:0] r_qj, r_qk;
   logic [31:0]             r_vj, r_vk, r_imm;
   logic [6:0]              r_opcode;
   logic [ROB_WIDTH-1:0]    r_rob_index;
   logic [4:0]              r_rd;

   logic [31:0]             w_imm;
   unit_e                   w_unit;
   logic                    w_use_rs1, w_use_rs2, w_has_rd;
   logic [4:0]              w_rs1, w_rs2, w_rd;
   logic                    w_hold, w_target_full, w_can_issue, w_advance, w_accept;
   logic [EX_ROB_WIDTH-1:0] w_qj, w_qk;
   logic [31:0]             w_vj, w_vk;

   imm_gen u_imm_gen (
      .inst    (r_inst),
      .imm     (w_imm),
      .unit    (w_unit),
      .use_rs1 (w_use_rs1),
      .use_rs2 (w_use_rs2),
      .has_rd  (w_has_rd)
   );

   assign w_rs1 = r_inst[19:15];
   assign w_rs2 = r_inst[24:20];
   assign w_rd  = r_inst[11:7];

   assign w_hold        = (r_state == c_hold);
   assign w_target_full = (w_unit == UNIT_RS) ? RS2DP_full :
                          (w_unit == UNIT_LSB) ? LSB2DP_full : 1'b0;
   assign w_can_issue   = w_hold && (w_unit != UNIT_NONE) && !ROB2DP_full && !w_target_full;
   // An unroutable opcode always leaves the register, so it never stalls fetch.
   assign w_advance     = w_can_issue || (w_hold && (w_unit == UNIT_NONE));
   assign DP2IF_stall   = w_hold && !w_advance;
   assign w_accept      = IF2DP_en && !DP2IF_stall;

   always_comb begin
      w_qj = RF2DP_Qj;
      w_vj = RF2DP_Vj;
      if (!w_use_rs1 || (w_rs1 == 5'd0)) begin
         w_qj = c_non_dep;
         w_vj = 32'd0;
      end else if (RF2DP_Qj != c_non_dep) begin
         if (RS2CDB_en && (RF2DP_Qj[ROB_WIDTH-1:0] == RS2CDB_ROB_index)) begin
            w_qj = c_non_dep;
            w_vj = RS2CDB_value;
         end else if (CDB2RS_LSB_en && (RF2DP_Qj[ROB_WIDTH-1:0] == CDB2RS_LSB_ROB_index)) begin
            w_qj = c_non_dep;
            w_vj = CDB2RS_LSB_value;
         end
      end
   end

   always_comb begin
      w_qk = RF2DP_Qk;
      w_vk = RF2DP_Vk;
      if (!w_use_rs2 || (w_rs2 == 5'd0)) begin
         w_qk = c_non_dep;
         w_vk = 32'd0;
      end else if (RF2DP_Qk != c_non_dep) begin
         if (RS2CDB_en && (RF2DP_Qk[ROB_WIDTH-1:0] == RS2CDB_ROB_index)) begin
            w_qk = c_non_dep;
            w_vk = RS2CDB_value;
         end else if (CDB2RS_LSB_en && (RF2DP_Qk[ROB_WIDTH-1:0] == CDB2RS_LSB_ROB_index)) begin
            w_qk = c_non_dep;
            w_vk = CDB2RS_LSB_value;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_state     <= c_idle;
         r_inst      <= 32'd0;
         r_pc        <= '0;
         r_rs_en     <= 1'b0;
         r_lsb_en    <= 1'b0;
         r_rob_en    <= 1'b0;
         r_rename_en <= 1'b0;
         r_issue_pc  <= '0;
         r_qj        <= '0;
         r_qk        <= '0;
         r_vj        <= 32'd0;
         r_vk        <= 32'd0;
         r_imm       <= 32'd0;
         r_opcode    <= 7'd0;
         r_rob_index <= '0;
         r_rd        <= 5'd0;
      end else if (ROB2DP_clear) begin
         r_state     <= c_idle;
         r_rs_en     <= 1'b0;
         r_lsb_en    <= 1'b0;
         r_rob_en    <= 1'b0;
         r_rename_en <= 1'b0;
      end else if (!rdy_in) begin
         r_rs_en     <= 1'b0;
         r_lsb_en    <= 1'b0;
         r_rob_en    <= 1'b0;
         r_rename_en <= 1'b0;
      end else begin
         r_rs_en     <= w_can_issue && (w_unit == UNIT_RS);
         r_lsb_en    <= w_can_issue && (w_unit == UNIT_LSB);
         r_rob_en    <= w_can_issue;
         r_rename_en <= w_can_issue && w_has_rd && (w_rd != 5'd0);
         if (w_can_issue) begin
            r_issue_pc  <= r_pc;
            r_qj        <= w_qj;
            r_qk        <= w_qk;
            r_vj        <= w_vj;
            r_vk        <= w_vk;
            r_imm       <= w_imm;
            r_opcode    <= r_inst[6:0];
            r_rob_index <= ROB2DP_tail;
            r_rd        <= w_has_rd ? w_rd : 5'd0;
         end
         if (w_accept) begin
            r_inst  <= IF2DP_inst;
            r_pc    <= IF2DP_pc;
            r_state <= c_hold;
         end else if (w_advance) begin
            r_state <= c_idle;
         end
      end
   end

   assign DP2RF_rs1        = w_rs1;
   assign DP2RF_rs2        = w_rs2;
   assign DP2RF_rename_en  = r_rename_en;
   assign DP2RF_rd         = r_rd;
   assign DP2RF_ROB_index  = r_rob_index;
   assign DP2ROB_en        = r_rob_en;
   assign DP2ROB_opcode    = r_opcode;
   assign DP2ROB_rd        = r_rd;
   assign DP2ROB_pc        = r_issue_pc;
   assign DP2RS_en         = r_rs_en;
   assign DP2RS_pc         = r_issue_pc;
   assign DP2RS_Qj         = r_qj;
   assign DP2RS_Qk         = r_qk;
   assign DP2RS_Vj         = r_vj;
   assign DP2RS_Vk         = r_vk;
   assign DP2RS_imm        = r_imm;
   assign DP2RS_opcode     = r_opcode;
   assign DP2RS_ROB_index  = r_rob_index;
   assign DP2LSB_en        = r_lsb_en;
   assign DP2LSB_pc        = r_issue_pc;
   assign DP2LSB_Qj        = r_qj;
   assign DP2LSB_Qk        = r_qk;
   assign DP2LSB_Vj        = r_vj;
   assign DP2LSB_Vk        = r_vk;
   assign DP2LSB_imm       = r_imm;
   assign DP2LSB_opcode    = r_opcode;
   assign DP2LSB_ROB_index = r_rob_index;
endmodule

`default_nettype wire

// File: tb/tb_dispatcher.sv
// ==========================================================================
// Module : tb_dispatcher
// Directed self-checking bench for the dispatcher.
// Rev    : 1.0
// ==========================================================================
`default_nettype none

module tb_dispatcher;
   logic        clk_in, rst_in, rdy_in;
   logic        IF2DP_en;
   logic [31:0] IF2DP_inst, IF2DP_pc;
   logic        DP2IF_stall;
   logic [4:0]  DP2RF_rs1, DP2RF_rs2;
   logic [4:0]  RF2DP_Qj, RF2DP_Qk;
   logic [31:0] RF2DP_Vj, RF2DP_Vk;
   logic        DP2RF_rename_en;
   logic [4:0]  DP2RF_rd;
   logic [3:0]  DP2RF_ROB_index;
   logic        ROB2DP_full, ROB2DP_clear;
   logic [3:0]  ROB2DP_tail;
   logic        DP2ROB_en;
   logic [6:0]  DP2ROB_opcode;
   logic [4:0]  DP2ROB_rd;
   logic [31:0] DP2ROB_pc;
   logic        DP2RS_en, DP2LSB_en, RS2DP_full, LSB2DP_full;
   logic [31:0] DP2RS_pc, DP2LSB_pc;
   logic [4:0]  DP2RS_Qj, DP2RS_Qk, DP2LSB_Qj, DP2LSB_Qk;
   logic [31:0] DP2RS_Vj, DP2RS_Vk, DP2RS_imm, DP2LSB_Vj, DP2LSB_Vk, DP2LSB_imm;
   logic [6:0]  DP2RS_opcode, DP2LSB_opcode;
   logic [3:0]  DP2RS_ROB_index, DP2LSB_ROB_index;
   logic        RS2CDB_en, CDB2RS_LSB_en;
   logic [3:0]  RS2CDB_ROB_index, CDB2RS_LSB_ROB_index;
   logic [31:0] RS2CDB_value, CDB2RS_LSB_value;

   int checks = 0;
   int errors = 0;

   dispatcher dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .IF2DP_en(IF2DP_en), .IF2DP_inst(IF2DP_inst), .IF2DP_pc(IF2DP_pc), .DP2IF_stall(DP2IF_stall),
      .DP2RF_rs1(DP2RF_rs1), .DP2RF_rs2(DP2RF_rs2), .RF2DP_Qj(RF2DP_Qj), .RF2DP_Qk(RF2DP_Qk),
      .RF2DP_Vj(RF2DP_Vj), .RF2DP_Vk(RF2DP_Vk), .DP2RF_rename_en(DP2RF_rename_en),
      .DP2RF_rd(DP2RF_rd), .DP2RF_ROB_index(DP2RF_ROB_index),
      .ROB2DP_full(ROB2DP_full), .ROB2DP_tail(ROB2DP_tail), .ROB2DP_clear(ROB2DP_clear),
      .DP2ROB_en(DP2ROB_en), .DP2ROB_opcode(DP2ROB_opcode), .DP2ROB_rd(DP2ROB_rd), .DP2ROB_pc(DP2ROB_pc),
      .DP2RS_en(DP2RS_en), .DP2RS_pc(DP2RS_pc), .DP2RS_Qj(DP2RS_Qj), .DP2RS_Qk(DP2RS_Qk),
      .DP2RS_Vj(DP2RS_Vj), .DP2RS_Vk(DP2RS_Vk), .DP2RS_imm(DP2RS_imm), .DP2RS_opcode(DP2RS_opcode),
      .DP2RS_ROB_index(DP2RS_ROB_index), .RS2DP_full(RS2DP_full),
      .DP2LSB_en(DP2LSB_en), .DP2LSB_pc(DP2LSB_pc), .DP2LSB_Qj(DP2LSB_Qj), .DP2LSB_Qk(DP2LSB_Qk),
      .DP2LSB_Vj(DP2LSB_Vj), .DP2LSB_Vk(DP2LSB_Vk), .DP2LSB_imm(DP2LSB_imm), .DP2LSB_opcode(DP2LSB_opcode),
      .DP2LSB_ROB_index(DP2LSB_ROB_index), .LSB2DP_full(LSB2DP_full),
      .RS2CDB_en(RS2CDB_en), .RS2CDB_ROB_index(RS2CDB_ROB_index), .RS2CDB_value(RS2CDB_value),
      .CDB2RS_LSB_en(CDB2RS_LSB_en), .CDB2RS_LSB_ROB_index(CDB2RS_LSB_ROB_index),
      .CDB2RS_LSB_value(CDB2RS_LSB_value)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic tick;
      @(posedge clk_in);
      #1;
   endtask

   task automatic accept_inst(input logic [31:0] inst, input logic [31:0] pc);
      IF2DP_en = 1'b1; IF2DP_inst = inst; IF2DP_pc = pc;
      tick;
      IF2DP_en = 1'b0;
   endtask

   task automatic test_reset;
      rst_in = 1'b0;
      tick; tick;
      checks++;
      if ({DP2RS_en, DP2LSB_en, DP2ROB_en, DP2RF_rename_en, DP2IF_stall} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl got %b want 00000", {DP2RS_en, DP2LSB_en, DP2ROB_en, DP2RF_rename_en, DP2IF_stall});
      end
      checks++;
      if ({DP2RS_imm, DP2RS_pc, DP2RS_Vj, DP2ROB_opcode, DP2RS_ROB_index, DP2RS_Qj} !== '0) begin
         errors++; $display("FAIL reset_data got imm=%h pc=%h vj=%h op=%b idx=%h qj=%h want 0",
                            DP2RS_imm, DP2RS_pc, DP2RS_Vj, DP2ROB_opcode, DP2RS_ROB_index, DP2RS_Qj);
      end
      rst_in = 1'b1;
   endtask

   task automatic test_addi;
      ROB2DP_tail = 4'd2; RF2DP_Qj = 5'd16; RF2DP_Vj = 32'h1234; RF2DP_Qk = 5'd16; RF2DP_Vk = 32'h0;
      accept_inst(32'h00500093, 32'h0);
      checks++;
      if ({DP2IF_stall, DP2RS_en, DP2ROB_en} !== 3'b000) begin
         errors++; $display("FAIL addi_latency got %b want 000", {DP2IF_stall, DP2RS_en, DP2ROB_en});
      end
      tick;
      checks++;
      if ({DP2RS_en, DP2LSB_en, DP2ROB_en, DP2RF_rename_en} !== 4'b1011) begin
         errors++; $display("FAIL addi_en got %b want 1011", {DP2RS_en, DP2LSB_en, DP2ROB_en, DP2RF_rename_en});
      end
      checks++;
      if (DP2RS_opcode !== 7'b0010011 || DP2RS_imm !== 32'd5 || DP2RS_Qj !== 5'd16 || DP2RS_Qk !== 5'd16 || DP2RS_Vj !== 32'd0) begin
         errors++; $display("FAIL addi_data got op=%b imm=%h qj=%0d qk=%0d vj=%h want 0010011 5 16 16 0",
                            DP2RS_opcode, DP2RS_imm, DP2RS_Qj, DP2RS_Qk, DP2RS_Vj);
      end
      checks++;
      if (DP2RS_ROB_index !== 4'd2 || DP2RF_rd !== 5'd1 || DP2RF_ROB_index !== 4'd2 || DP2ROB_pc !== 32'h0 || DP2ROB_rd !== 5'd1) begin
         errors++; $display("FAIL addi_tags got idx=%0d rd=%0d rfidx=%0d pc=%h robrd=%0d want 2 1 2 0 1",
                            DP2RS_ROB_index, DP2RF_rd, DP2RF_ROB_index, DP2ROB_pc, DP2ROB_rd);
      end
      tick;
      checks++;
      if ({DP2RS_en, DP2LSB_en, DP2ROB_en, DP2RF_rename_en} !== 4'b0000) begin
         errors++; $display("FAIL addi_single_pulse got %b want 0000", {DP2RS_en, DP2LSB_en, DP2ROB_en, DP2RF_rename_en});
      end
   endtask

   task automatic test_store;
      ROB2DP_tail = 4'd5; RF2DP_Qj = 5'd16; RF2DP_Vj = 32'h100; RF2DP_Qk = 5'd16; RF2DP_Vk = 32'h55;
      accept_inst(32'h0020A423, 32'h100);
      checks++;
      if (DP2RF_rs1 !== 5'd1 || DP2RF_rs2 !== 5'd2) begin
         errors++; $display("FAIL sw_rf_query got rs1=%0d rs2=%0d want 1 2", DP2RF_rs1, DP2RF_rs2);
      end
      tick;
      checks++;
      if ({DP2RS_en, DP2LSB_en, DP2ROB_en, DP2RF_rename_en} !== 4'b0110) begin
         errors++; $display("FAIL sw_en got %b want 0110", {DP2RS_en, DP2LSB_en, DP2ROB_en, DP2RF_rename_en});
      end
      checks++;
      if (DP2LSB_imm !== 32'd8 || DP2LSB_Vj !== 32'h100 || DP2LSB_Vk !== 32'h55 || DP2LSB_ROB_index !== 4'd5
          || DP2LSB_pc !== 32'h100 || DP2LSB_opcode !== 7'b0100011) begin
         errors++; $display("FAIL sw_data got imm=%h vj=%h vk=%h idx=%0d pc=%h op=%b want 8 100 55 5 100 0100011",
                            DP2LSB_imm, DP2LSB_Vj, DP2LSB_Vk, DP2LSB_ROB_index, DP2LSB_pc, DP2LSB_opcode);
      end
      tick;
   endtask

   task automatic test_rs_full;
      ROB2DP_tail = 4'd6; RS2DP_full = 1'b1;
      accept_inst(32'h002081B3, 32'h200);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({DP2IF_stall, DP2RS_en, DP2ROB_en} !== 3'b100) begin
            errors++; $display("FAIL rsfull_stall cycle %0d got %b want 100", i, {DP2IF_stall, DP2RS_en, DP2ROB_en});
         end
         tick;
      end
      RS2DP_full = 1'b0;
      #1;
      checks++;
      if (DP2IF_stall !== 1'b0) begin
         errors++; $display("FAIL rsfull_release got stall=%b want 0", DP2IF_stall);
      end
      tick;
      checks++;
      if ({DP2RS_en, DP2ROB_en, DP2RS_ROB_index} !== {2'b11, 4'd6}) begin
         errors++; $display("FAIL rsfull_issue got en=%b%b idx=%0d want 11 6", DP2RS_en, DP2ROB_en, DP2RS_ROB_index);
      end
      tick;
      checks++;
      if (DP2RS_en !== 1'b0) begin
         errors++; $display("FAIL rsfull_one_pulse got %b want 0", DP2RS_en);
      end
   endtask

   task automatic test_forward;
      ROB2DP_tail = 4'd7;
      accept_inst(32'h002081B3, 32'h300);
      RF2DP_Qj = 5'd3; RF2DP_Vj = 32'h0; RF2DP_Qk = 5'd4; RF2DP_Vk = 32'h77;
      RS2CDB_en = 1'b1; RS2CDB_ROB_index = 4'd3; RS2CDB_value = 32'hDEADBEEF;
      CDB2RS_LSB_en = 1'b1; CDB2RS_LSB_ROB_index = 4'd9; CDB2RS_LSB_value = 32'h5555;
      tick;
      checks++;
      if (DP2RS_Qj !== 5'd16 || DP2RS_Vj !== 32'hDEADBEEF || DP2RS_Qk !== 5'd4 || DP2RS_Vk !== 32'h77) begin
         errors++; $display("FAIL fwd_rs got qj=%0d vj=%h qk=%0d vk=%h want 16 deadbeef 4 77", DP2RS_Qj, DP2RS_Vj, DP2RS_Qk, DP2RS_Vk);
      end
      accept_inst(32'h002081B3, 32'h304);
      RF2DP_Qj = 5'd9; RF2DP_Qk = 5'd8;
      RS2CDB_ROB_index = 4'd9; RS2CDB_value = 32'h11111111;
      CDB2RS_LSB_ROB_index = 4'd9; CDB2RS_LSB_value = 32'h22222222;
      tick;
      checks++;
      if (DP2RS_Qj !== 5'd16 || DP2RS_Vj !== 32'h11111111 || DP2RS_Qk !== 5'd8) begin
         errors++; $display("FAIL fwd_priority got qj=%0d vj=%h qk=%0d want 16 11111111 8", DP2RS_Qj, DP2RS_Vj, DP2RS_Qk);
      end
      accept_inst(32'h002081B3, 32'h308);
      RS2CDB_en = 1'b0; CDB2RS_LSB_ROB_index = 4'd8;
      tick;
      checks++;
      if (DP2RS_Qj !== 5'd9 || DP2RS_Qk !== 5'd16 || DP2RS_Vk !== 32'h22222222) begin
         errors++; $display("FAIL fwd_lsb got qj=%0d qk=%0d vk=%h want 9 16 22222222", DP2RS_Qj, DP2RS_Qk, DP2RS_Vk);
      end
      CDB2RS_LSB_en = 1'b0; RF2DP_Qj = 5'd16; RF2DP_Qk = 5'd16;
      tick;
   endtask

   task automatic test_back_to_back;
      accept_inst(32'h00500093, 32'h10);
      ROB2DP_tail = 4'd3;
      IF2DP_en = 1'b1; IF2DP_inst = 32'h00700113; IF2DP_pc = 32'h14;
      tick;
      IF2DP_en = 1'b0; ROB2DP_tail = 4'd4;
      checks++;
      if (DP2RS_en !== 1'b1 || DP2RS_imm !== 32'd5 || DP2RS_ROB_index !== 4'd3 || DP2RS_pc !== 32'h10 || DP2IF_stall !== 1'b0) begin
         errors++; $display("FAIL b2b_first got en=%b imm=%h idx=%0d pc=%h stall=%b want 1 5 3 10 0",
                            DP2RS_en, DP2RS_imm, DP2RS_ROB_index, DP2RS_pc, DP2IF_stall);
      end
      tick;
      checks++;
      if (DP2RS_en !== 1'b1 || DP2RS_imm !== 32'd7 || DP2RS_ROB_index !== 4'd4 || DP2RS_pc !== 32'h14 || DP2RF_rd !== 5'd2) begin
         errors++; $display("FAIL b2b_second got en=%b imm=%h idx=%0d pc=%h rd=%0d want 1 7 4 14 2",
                            DP2RS_en, DP2RS_imm, DP2RS_ROB_index, DP2RS_pc, DP2RF_rd);
      end
      tick;
      checks++;
      if (DP2RS_en !== 1'b0) begin
         errors++; $display("FAIL b2b_end got %b want 0", DP2RS_en);
      end
   endtask

   task automatic test_nop;
      accept_inst(32'h0000000F, 32'h40);
      checks++;
      if (DP2IF_stall !== 1'b0) begin
         errors++; $display("FAIL nop_stall got %b want 0", DP2IF_stall);
      end
      for (int i = 0; i < 2; i++) begin
         tick;
         checks++;
         if ({DP2RS_en, DP2LSB_en, DP2ROB_en, DP2RF_rename_en} !== 4'b0000) begin
            errors++; $display("FAIL nop_no_issue cycle %0d got %b want 0000", i, {DP2RS_en, DP2LSB_en, DP2ROB_en, DP2RF_rename_en});
         end
      end
   endtask

   task automatic test_rdy;
      ROB2DP_tail = 4'd1;
      accept_inst(32'h00500093, 32'h50);
      rdy_in = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick;
         checks++;
         if ({DP2RS_en, DP2ROB_en} !== 2'b00) begin
            errors++; $display("FAIL rdy_pause cycle %0d got %b want 00", i, {DP2RS_en, DP2ROB_en});
         end
      end
      rdy_in = 1'b1;
      tick;
      checks++;
      if ({DP2RS_en, DP2ROB_en, DP2RS_pc} !== {2'b11, 32'h50}) begin
         errors++; $display("FAIL rdy_resume got en=%b%b pc=%h want 11 50", DP2RS_en, DP2ROB_en, DP2RS_pc);
      end
      tick;
   endtask

   task automatic test_clear;
      ROB2DP_full = 1'b1;
      accept_inst(32'h002081B3, 32'h60);
      checks++;
      if (DP2IF_stall !== 1'b1) begin
         errors++; $display("FAIL clear_pre_stall got %b want 1", DP2IF_stall);
      end
      ROB2DP_clear = 1'b1; IF2DP_en = 1'b1; IF2DP_inst = 32'h00700113; IF2DP_pc = 32'h64;
      tick;
      ROB2DP_clear = 1'b0; IF2DP_en = 1'b0; ROB2DP_full = 1'b0;
      checks++;
      if ({DP2RS_en, DP2LSB_en, DP2ROB_en, DP2RF_rename_en, DP2IF_stall} !== 5'b00000) begin
         errors++; $display("FAIL clear_flush got %b want 00000", {DP2RS_en, DP2LSB_en, DP2ROB_en, DP2RF_rename_en, DP2IF_stall});
      end
      tick;
      checks++;
      if ({DP2RS_en, DP2ROB_en} !== 2'b00) begin
         errors++; $display("FAIL clear_idle got %b want 00", {DP2RS_en, DP2ROB_en});
      end
   endtask

   task automatic test_rst_mid;
      ROB2DP_tail = 4'd9;
      accept_inst(32'h00500093, 32'h70);
      rst_in = 1'b0;
      tick;
      rst_in = 1'b1;
      checks++;
      if ({DP2RS_en, DP2LSB_en, DP2ROB_en, DP2RF_rename_en} !== 4'b0000) begin
         errors++; $display("FAIL rstmid_abort got %b want 0000", {DP2RS_en, DP2LSB_en, DP2ROB_en, DP2RF_rename_en});
      end
      tick;
      checks++;
      if ({DP2RS_en, DP2ROB_en, DP2IF_stall} !== 3'b000 || DP2RS_imm !== 32'd0 || DP2RS_pc !== 32'd0
          || DP2RS_ROB_index !== 4'd0 || DP2RS_opcode !== 7'd0 || DP2RF_rd !== 5'd0) begin
         errors++; $display("FAIL rstmid_outputs got en=%b%b stall=%b imm=%h pc=%h idx=%0d op=%b rd=%0d want all 0",
                            DP2RS_en, DP2ROB_en, DP2IF_stall, DP2RS_imm, DP2RS_pc, DP2RS_ROB_index, DP2RS_opcode, DP2RF_rd);
      end
   endtask

   initial begin
      rst_in = 1'b0; rdy_in = 1'b1;
      IF2DP_en = 1'b0; IF2DP_inst = 32'h0; IF2DP_pc = 32'h0;
      RF2DP_Qj = 5'd16; RF2DP_Qk = 5'd16; RF2DP_Vj = 32'h0; RF2DP_Vk = 32'h0;
      ROB2DP_full = 1'b0; ROB2DP_tail = 4'd0; ROB2DP_clear = 1'b0;
      RS2DP_full = 1'b0; LSB2DP_full = 1'b0;
      RS2CDB_en = 1'b0; RS2CDB_ROB_index = 4'd0; RS2CDB_value = 32'h0;
      CDB2RS_LSB_en = 1'b0; CDB2RS_LSB_ROB_index = 4'd0; CDB2RS_LSB_value = 32'h0;
      test_reset;
      test_addi;
      test_store;
      test_rs_full;
      test_forward;
      test_back_to_back;
      test_nop;
      test_rdy;
      test_clear;
      test_rst_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
